// File: rtl/data_mem_pkg.sv
// Shared types and constants for the data memory request/response front-end.
package data_mem_pkg;

    localparam int DATA_W    = 32;
    localparam int ADDR_W    = 32;
    localparam int MEM_WORDS = 65536;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        CAPTURE,
        RESP
    } state_e;

    typedef struct packed {
        logic              write;
        logic              err;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } req_t;

    function automatic logic addr_out_of_range(input logic [ADDR_W-1:0] addr);
        return addr >= ADDR_W'(MEM_WORDS);
    endfunction

endpackage

// File: rtl/data_mem_req_fifo.sv
// Small synchronous request FIFO with simultaneous push/pop and occupancy count.
module data_mem_req_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           push_data_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           pop_data_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             push_en, pop_en;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full_o     = (count_q == CNT_W'(DEPTH));
    assign empty_o    = (count_q == '0);
    assign count_o    = count_q;
    assign push_en    = push_i && !full_o;
    assign pop_en     = pop_i && !empty_o;
    assign pop_data_o = mem_q[rd_ptr_q];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_en) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= ptr_inc(wr_ptr_q);
            end
            if (pop_en) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            case ({push_en, pop_en})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/data_mem_ctrl.sv
// MEM-stage front-end: buffers load/store requests, drives the single-cycle data
// memory port, and returns one in-order response per accepted request.
//
//   state   | meaning
//   IDLE    | no op in flight; waiting for a buffered request
//   ISSUE   | memory strobe cycle for the op register (strobes muted for errors)
//   CAPTURE | memory read data valid; latch into the response register
//   RESP    | response presented, held until in_resp_ready
module data_mem_ctrl
    import data_mem_pkg::*;
#(
    parameter int FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              in_rst_n,
    input  logic              in_req_valid,
    output logic              out_req_ready,
    input  logic              in_req_write,
    input  logic [ADDR_W-1:0] in_req_addr,
    input  logic [DATA_W-1:0] in_req_data,
    output logic              out_resp_valid,
    input  logic              in_resp_ready,
    output logic [DATA_W-1:0] out_resp_data,
    output logic              out_resp_write,
    output logic              out_resp_err,
    output logic              out_mem_read,
    output logic              out_mem_write,
    output logic [31:0]       out_mem_addr,
    output logic [DATA_W-1:0] out_mem_data,
    input  logic [DATA_W-1:0] in_mem_data
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    state_e            state_q, state_d;
    req_t              op_q, op_d;
    req_t              push_req, fifo_head;
    logic [DATA_W-1:0] resp_data_q, resp_data_d;
    logic              resp_write_q, resp_write_d;
    logic              resp_err_q, resp_err_d;
    logic              fifo_full, fifo_empty, fifo_push, fifo_pop, take_head;
    logic [CNT_W-1:0]  fifo_count;

    assign out_req_ready = (fifo_count < CNT_W'(FIFO_DEPTH));
    assign fifo_push     = in_req_valid && !fifo_full;
    assign push_req      = '{write: in_req_write,
                             err:   addr_out_of_range(in_req_addr),
                             addr:  in_req_addr,
                             data:  in_req_data};

    data_mem_req_fifo #(
        .WIDTH($bits(req_t)),
        .DEPTH(FIFO_DEPTH)
    ) u_req_fifo (
        .clk         (clk),
        .rst_n       (in_rst_n),
        .push_i      (fifo_push),
        .push_data_i (push_req),
        .pop_i       (fifo_pop),
        .pop_data_o  (fifo_head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count)
    );

    // Errors also spend one ISSUE cycle (strobes muted) so they keep the same
    // two-cycle cadence as stores. Their address never enters the op register,
    // which keeps the memory address/data pins at the last real access.
    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        resp_data_d   = resp_data_q;
        resp_write_d  = resp_write_q;
        resp_err_d    = resp_err_q;
        fifo_pop      = 1'b0;
        take_head     = 1'b0;
        out_mem_read  = 1'b0;
        out_mem_write = 1'b0;

        case (state_q)
            IDLE: begin
                take_head = !fifo_empty;
            end
            ISSUE: begin
                out_mem_read  = !op_q.write && !op_q.err;
                out_mem_write = op_q.write && !op_q.err;
                state_d       = (op_q.write || op_q.err) ? RESP : CAPTURE;
            end
            CAPTURE: begin
                resp_data_d = in_mem_data;
                state_d     = RESP;
            end
            RESP: begin
                if (in_resp_ready) begin
                    state_d   = IDLE;
                    take_head = !fifo_empty;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (take_head) begin
            fifo_pop     = 1'b1;
            state_d      = ISSUE;
            op_d.write   = fifo_head.write;
            op_d.err     = fifo_head.err;
            resp_write_d = fifo_head.write;
            resp_err_d   = fifo_head.err;
            resp_data_d  = '0;
            if (!fifo_head.err) begin
                op_d.addr = fifo_head.addr;
                op_d.data = fifo_head.data;
            end
        end
    end

    always_ff @(posedge clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            state_q      <= IDLE;
            op_q         <= '0;
            resp_data_q  <= '0;
            resp_write_q <= 1'b0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            resp_data_q  <= resp_data_d;
            resp_write_q <= resp_write_d;
            resp_err_q   <= resp_err_d;
        end
    end

    assign out_resp_valid = (state_q == RESP);
    assign out_resp_data  = resp_data_q;
    assign out_resp_write = resp_write_q;
    assign out_resp_err   = resp_err_q;
    assign out_mem_addr   = op_q.addr;
    assign out_mem_data   = op_q.data;

endmodule
